// File: rtl/sram_wb_bridge_pkg.sv
// ============================================================================
//  Module      : sram_wb_bridge_pkg
//  Description : Shared types, widths and lane-mapping helpers for the
//                Wishbone-to-asynchronous-SRAM bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_wb_bridge_pkg;

    // 256K x 16 part: 18-bit half-word address, 19-bit byte address.
    localparam int SRAM_AW = 18;
    localparam int BYTE_AW = 19;

    // Half index values: half 0 carries the two lowest byte addresses.
    localparam logic HALF_UPPER_WORD = 1'b0;
    localparam logic HALF_LOWER_WORD = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_HOLD   = 3'd3,
        ST_ACK    = 3'd4
    } state_t;

    // Active-high byte enables for one half, returned as {upper_lane, lower_lane}.
    // Big-endian bus: the lowest byte address of each half sits on DQ[7:0].
    function automatic logic [1:0] half_sel(input logic [3:0] sel, input logic h);
        return (h == HALF_UPPER_WORD) ? {sel[2], sel[3]} : {sel[0], sel[1]};
    endfunction

    // Write data presented on DQ for one half.
    function automatic logic [15:0] half_wdata(input logic [31:0] dat, input logic h);
        return (h == HALF_UPPER_WORD) ? {dat[23:16], dat[31:24]} : {dat[7:0], dat[15:8]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_wb_bridge.sv
// ============================================================================
//  Module      : sram_wb_bridge
//  Description : Wishbone classic slave turning 32-bit word accesses into one
//                or two 16-bit asynchronous SRAM cycles. All SRAM controls and
//                the DQ drive are registered so the pins never glitch.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_wb_bridge
    import sram_wb_bridge_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [31:0]         wb_adr_i,
    input  logic [31:0]         wb_dat_i,
    output logic [31:0]         wb_dat_o,
    input  logic [3:0]          wb_sel_i,
    input  logic                wb_we_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    output logic                wb_ack_o,
    inout  wire  [15:0]         SRAM_DQ,
    output logic [SRAM_AW-1:0]  SRAM_ADDR,
    output logic                SRAM_UB_N,
    output logic                SRAM_LB_N,
    output logic                SRAM_WE_N,
    output logic                SRAM_CE_N,
    output logic                SRAM_OE_N
);

    // Strobe-width counter: loaded with WAIT_CYCLES-1, ACCESS ends at zero.
    localparam int            CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic                   h_q, h_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    // Request copies taken in IDLE; later bus activity is ignored.
    logic [BYTE_AW-1:2]     adr_q, adr_d;
    logic [31:0]            dat_q, dat_d;
    logic [3:0]             sel_q, sel_d;
    logic                   we_q, we_d;

    logic [31:0]            rdat_q, rdat_d;
    logic                   ack_q, ack_d;
    logic [SRAM_AW-1:0]     addr_q, addr_d;
    logic                   ce_n_q, ce_n_d;
    logic                   we_n_q, we_n_d;
    logic                   oe_n_q, oe_n_d;
    logic                   ub_n_q, ub_n_d;
    logic                   lb_n_q, lb_n_d;
    logic                   dq_oe_q, dq_oe_d;
    logic [15:0]            dq_out_q, dq_out_d;

    logic [1:0]             w_rd_lanes;
    logic [1:0]             w_lanes;
    logic [7:0]             w_rd_lo;
    logic [7:0]             w_rd_hi;

    // Byte-offset and upstream-decoded address bits are not needed here.
    logic                   w_unused_adr;
    assign w_unused_adr = ^{wb_adr_i[31:BYTE_AW], wb_adr_i[1:0]};

    // Next-state, request latching and read-data capture.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        rdat_d  = rdat_q;

        // Unselected lanes of the captured half read as zero.
        w_rd_lanes = half_sel(sel_q, h_q);
        w_rd_lo    = w_rd_lanes[0] ? SRAM_DQ[7:0]  : 8'h00;
        w_rd_hi    = w_rd_lanes[1] ? SRAM_DQ[15:8] : 8'h00;

        case (state_q)
            ST_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    adr_d = wb_adr_i[BYTE_AW-1:2];
                    dat_d = wb_dat_i;
                    sel_d = wb_sel_i;
                    we_d  = wb_we_i;
                    if (|wb_sel_i[3:2]) begin
                        state_d = ST_SETUP;
                        h_d     = HALF_UPPER_WORD;
                    end else if (|wb_sel_i[1:0]) begin
                        state_d = ST_SETUP;
                        h_d     = HALF_LOWER_WORD;
                    end else begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = CNT_LOAD;
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    if (!we_q) begin
                        if (h_q == HALF_UPPER_WORD) begin
                            rdat_d = {w_rd_lo, w_rd_hi, 16'h0000};
                        end else begin
                            rdat_d[15:0] = {w_rd_lo, w_rd_hi};
                            // Upper half was skipped, so it must not show stale data.
                            if (sel_q[3:2] == 2'b00) begin
                                rdat_d[31:16] = 16'h0000;
                            end
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_HOLD: begin
                if ((h_q == HALF_UPPER_WORD) && (|sel_q[1:0])) begin
                    state_d = ST_SETUP;
                    h_d     = HALF_LOWER_WORD;
                end else begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pin values for the state being entered, so every pin comes from a flop.
    always_comb begin
        addr_d   = addr_q;
        ce_n_d   = 1'b1;
        we_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        ub_n_d   = 1'b1;
        lb_n_d   = 1'b1;
        dq_oe_d  = 1'b0;
        dq_out_d = dq_out_q;
        ack_d    = 1'b0;
        w_lanes  = half_sel(sel_d, h_d);

        case (state_d)
            ST_SETUP, ST_ACCESS, ST_HOLD: begin
                addr_d   = {adr_d, h_d};
                ce_n_d   = 1'b0;
                ub_n_d   = ~w_lanes[1];
                lb_n_d   = ~w_lanes[0];
                dq_oe_d  = we_d;
                dq_out_d = half_wdata(dat_d, h_d);
                if (state_d == ST_ACCESS) begin
                    we_n_d = ~we_d;
                    oe_n_d = we_d;
                end
            end
            ST_ACK: begin
                ack_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State, request copies and registered pin drivers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            h_q      <= 1'b0;
            cnt_q    <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            rdat_q   <= '0;
            ack_q    <= 1'b0;
            addr_q   <= '0;
            ce_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            ub_n_q   <= 1'b1;
            lb_n_q   <= 1'b1;
            dq_oe_q  <= 1'b0;
            dq_out_q <= '0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            cnt_q    <= cnt_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            rdat_q   <= rdat_d;
            ack_q    <= ack_d;
            addr_q   <= addr_d;
            ce_n_q   <= ce_n_d;
            we_n_q   <= we_n_d;
            oe_n_q   <= oe_n_d;
            ub_n_q   <= ub_n_d;
            lb_n_q   <= lb_n_d;
            dq_oe_q  <= dq_oe_d;
            dq_out_q <= dq_out_d;
        end
    end

    assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign SRAM_ADDR = addr_q;
    assign SRAM_CE_N = ce_n_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_UB_N = ub_n_q;
    assign SRAM_LB_N = lb_n_q;
    assign wb_dat_o  = rdat_q;
    assign wb_ack_o  = ack_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_wb_bridge.sv
// ============================================================================
//  Module      : tb_sram_wb_bridge
//  Description : Directed bench for sram_wb_bridge with a behavioural SRAM per
//                bridge instance (WAIT_CYCLES = 1 and WAIT_CYCLES = 3).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_wb_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic        we, stb, cyc_a, cyc_b;

    wire  [31:0] rdat_a, rdat_b;
    wire         ack_a, ack_b;
    tri   [15:0] dq_a, dq_b;
    wire  [17:0] addr_a, addr_b;
    wire         ub_a, lb_a, we_n_a, ce_a, oe_a;
    wire         ub_b, lb_b, we_n_b, ce_b, oe_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_wb_bridge #(.WAIT_CYCLES(1)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat_a),
        .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc_a), .wb_stb_i(stb), .wb_ack_o(ack_a),
        .SRAM_DQ(dq_a), .SRAM_ADDR(addr_a), .SRAM_UB_N(ub_a), .SRAM_LB_N(lb_a),
        .SRAM_WE_N(we_n_a), .SRAM_CE_N(ce_a), .SRAM_OE_N(oe_a)
    );

    sram_wb_bridge #(.WAIT_CYCLES(3)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat_b),
        .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc_b), .wb_stb_i(stb), .wb_ack_o(ack_b),
        .SRAM_DQ(dq_b), .SRAM_ADDR(addr_b), .SRAM_UB_N(ub_b), .SRAM_LB_N(lb_b),
        .SRAM_WE_N(we_n_b), .SRAM_CE_N(ce_b), .SRAM_OE_N(oe_b)
    );

    // Behavioural 256K x 16 SRAMs: read drives DQ while CE and OE are low,
    // write stores the enabled bytes at each clock edge with CE and WE low.
    logic [15:0] mem_a [0:262143];
    logic [15:0] mem_b [0:262143];

    assign dq_a = (!ce_a && !oe_a && we_n_a) ? mem_a[addr_a] : 16'hzzzz;
    assign dq_b = (!ce_b && !oe_b && we_n_b) ? mem_b[addr_b] : 16'hzzzz;

    always @(posedge clk) begin
        if (!ce_a && !we_n_a) begin
            if (!lb_a) mem_a[addr_a][7:0]  <= dq_a[7:0];
            if (!ub_a) mem_a[addr_a][15:8] <= dq_a[15:8];
        end
        if (!ce_b && !we_n_b) begin
            if (!lb_b) mem_b[addr_b][7:0]  <= dq_b[7:0];
            if (!ub_b) mem_b[addr_b][15:8] <= dq_b[15:8];
        end
    end

    // Pin monitor: strobe-cycle counts, address trace and invariant violations.
    wire         dqz_a = (dq_a === 16'hzzzz);
    wire         dqz_b = (dq_b === 16'hzzzz);
    wire  [1:0]  ce_m  = {ce_b, ce_a};
    wire  [1:0]  oe_m  = {oe_b, oe_a};
    wire  [1:0]  we_m  = {we_n_b, we_n_a};
    wire  [1:0]  ub_m  = {ub_b, ub_a};
    wire  [1:0]  lb_m  = {lb_b, lb_a};
    wire  [1:0]  dqz_m = {dqz_b, dqz_a};
    logic [17:0] addr_m [2];
    assign addr_m[0] = addr_a;
    assign addr_m[1] = addr_b;

    int          oe_lo [2] = '{0, 0};
    int          we_lo [2] = '{0, 0};
    int          ce_lo [2] = '{0, 0};
    int          viol  [2] = '{0, 0};
    logic [17:0] first_addr [2];
    logic [17:0] last_addr  [2];
    logic [17:0] prev_addr  [2];
    logic        prev_we_n  [2] = '{1'b1, 1'b1};
    logic        prev_ce_n  [2] = '{1'b1, 1'b1};
    logic        last_ub    [2];
    logic        last_lb    [2];
    bit          rd_active  [2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int v;
            v = 0;
            if (!oe_m[i]) oe_lo[i] <= oe_lo[i] + 1;
            if (!we_m[i]) begin
                we_lo[i]   <= we_lo[i] + 1;
                last_ub[i] <= ub_m[i];
                last_lb[i] <= lb_m[i];
            end
            if (!ce_m[i]) begin
                ce_lo[i]     <= ce_lo[i] + 1;
                last_addr[i] <= addr_m[i];
                if (prev_ce_n[i]) first_addr[i] <= addr_m[i];
            end
            if (!we_m[i] && !oe_m[i]) v++;
            if (!we_m[i] && !prev_we_n[i] && (addr_m[i] != prev_addr[i])) v++;
            if (rd_active[i] && oe_m[i] && !dqz_m[i]) v++;
            viol[i]      <= viol[i] + v;
            prev_we_n[i] <= we_m[i];
            prev_ce_n[i] <= ce_m[i];
            prev_addr[i] <= addr_m[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Per-transaction results.
    int          lat;
    logic [31:0] rd;
    int          d_oe, d_we, d_ce;

    // One Wishbone access; lat = edge index (request edge = 0) after which ack is seen.
    task automatic wb_access(input bit b, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s);
        int base_oe, base_we, base_ce;
        @(posedge clk); #1;
        base_oe = oe_lo[b];
        base_we = we_lo[b];
        base_ce = ce_lo[b];
        adr = a; wdat = d; sel = s; we = w; stb = 1'b1;
        if (b) cyc_b = 1'b1; else cyc_a = 1'b1;
        rd_active[b] = !w;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if ((b ? ack_b : ack_a) === 1'b1) begin
                lat = k;
                break;
            end
        end
        rd = b ? rdat_b : rdat_a;
        stb = 1'b0; cyc_a = 1'b0; cyc_b = 1'b0;
        adr = 32'hFFFF_FFFF; wdat = 32'h5A5A_5A5A; sel = 4'hF;
        @(posedge clk); #1;
        rd_active[b] = 1'b0;
        d_oe = oe_lo[b] - base_oe;
        d_we = we_lo[b] - base_we;
        d_ce = ce_lo[b] - base_ce;
    endtask

    initial begin
        bit found;
        rst = 1'b1; adr = '0; wdat = '0; sel = '0; we = 1'b0; stb = 1'b0;
        cyc_a = 1'b0; cyc_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack_a",  {31'd0, ack_a}, 32'd0);
        check("rst_dat_a",  rdat_a, 32'h0);
        check("rst_ctl_a",  {27'd0, ce_a, we_n_a, oe_a, ub_a, lb_a}, 32'h1F);
        check("rst_addr_a", {14'd0, addr_a}, 32'h0);
        check("rst_dqz_a",  {31'd0, dqz_a}, 32'd1);
        check("rst_dat_b",  rdat_b, 32'h0);
        check("rst_ctl_b",  {27'd0, ce_b, we_n_b, oe_b, ub_b, lb_b}, 32'h1F);
        rst = 1'b0;

        // Full-word write, two halves.
        wb_access(1'b0, 1'b1, 32'h100, 32'h1122_3344, 4'hF);
        check("wr_lat",     lat, 32'd6);
        check("wr_mem080",  {16'd0, mem_a[18'h080]}, 32'h2211);
        check("wr_mem081",  {16'd0, mem_a[18'h081]}, 32'h4433);
        check("wr_we_cyc",  d_we, 32'd2);
        check("wr_addr0",   {14'd0, first_addr[0]}, 32'h080);
        check("wr_addr1",   {14'd0, last_addr[0]}, 32'h081);

        // Read-back.
        wb_access(1'b0, 1'b0, 32'h100, 32'h0, 4'hF);
        check("rd_lat",     lat, 32'd6);
        check("rd_data",    rd, 32'h1122_3344);
        check("rd_oe_cyc",  d_oe, 32'd2);
        check("rd_we_cyc",  d_we, 32'd0);

        // Single byte in half 1.
        wb_access(1'b0, 1'b1, 32'h100, 32'hAABB_CCDD, 4'b0010);
        check("bw_lat",     lat, 32'd3);
        check("bw_mem081",  {16'd0, mem_a[18'h081]}, 32'h44CC);
        check("bw_mem080",  {16'd0, mem_a[18'h080]}, 32'h2211);
        check("bw_ub_lb",   {30'd0, last_ub[0], last_lb[0]}, 32'b10);
        check("bw_addr",    {14'd0, first_addr[0]}, 32'h081);
        check("bw_we_cyc",  d_we, 32'd1);

        wb_access(1'b0, 1'b0, 32'h100, 32'h0, 4'hF);
        check("bw_rd_data", rd, 32'h1122_CC44);
        check("bw_rd_lat",  lat, 32'd6);

        // Partial read: only byte +1 selected, the rest reads zero.
        wb_access(1'b0, 1'b0, 32'h100, 32'h0, 4'b0100);
        check("pr_data",    rd, 32'h0022_0000);
        check("pr_lat",     lat, 32'd3);
        check("pr_oe_cyc",  d_oe, 32'd1);

        // Half-1-only read must clear the skipped upper half.
        wb_access(1'b0, 1'b0, 32'h100, 32'h0, 4'b0001);
        check("pr1_data",   rd, 32'h0000_0044);

        // sel = 0: ack without SRAM activity; read data held.
        wb_access(1'b0, 1'b1, 32'h100, 32'hFFFF_FFFF, 4'h0);
        check("s0w_lat",    lat, 32'd0);
        check("s0w_ce_cyc", d_ce, 32'd0);
        check("s0w_mem",    {16'd0, mem_a[18'h080]}, 32'h2211);
        wb_access(1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
        check("s0r_lat",    lat, 32'd0);
        check("s0r_held",   rd, 32'h0000_0044);
        check("s0r_ce_cyc", d_ce, 32'd0);

        // Three wait states at the top of memory.
        wb_access(1'b1, 1'b1, 32'h7FFFC, 32'h0102_0304, 4'hF);
        check("w3w_lat",    lat, 32'd10);
        check("w3w_we_cyc", d_we, 32'd6);
        check("w3w_memE",   {16'd0, mem_b[18'h3FFFE]}, 32'h0201);
        check("w3w_memF",   {16'd0, mem_b[18'h3FFFF]}, 32'h0403);
        wb_access(1'b1, 1'b0, 32'h7FFFC, 32'h0, 4'hF);
        check("w3r_lat",    lat, 32'd10);
        check("w3r_data",   rd, 32'h0102_0304);
        check("w3r_oe_cyc", d_oe, 32'd6);
        check("w3r_addr0",  {14'd0, first_addr[1]}, 32'h3FFFE);
        check("w3r_addr1",  {14'd0, last_addr[1]}, 32'h3FFFF);

        // Reset during the ACCESS of half 0 of a write.
        @(posedge clk); #1;
        adr = 32'h200; wdat = 32'hDEAD_BEEF; sel = 4'hF; we = 1'b1; stb = 1'b1; cyc_a = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (we_n_a === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        check("mr_we_seen", {31'd0, found}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mr_ctl",     {27'd0, ce_a, we_n_a, oe_a, ub_a, lb_a}, 32'h1F);
        check("mr_dqz",     {31'd0, dqz_a}, 32'd1);
        check("mr_ack",     {31'd0, ack_a}, 32'd0);
        cyc_a = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        check("mr_ack2",    {31'd0, ack_a}, 32'd0);
        rst = 1'b0;
        wb_access(1'b0, 1'b0, 32'h100, 32'h0, 4'hF);
        check("mr_rd_lat",  lat, 32'd6);
        check("mr_rd_data", rd, 32'h1122_CC44);

        check("inv_a",      viol[0], 32'd0);
        check("inv_b",      viol[1], 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
